// File: rtl/div_share_pkg.sv
// Shared types and timing helpers for the divider-sharing controller.
// State encoding and latency/timeout helpers used by the RTL and its bench.
package div_share_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCEPT = 3'd1,
        ISSUE  = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4
    } state_e;

    // Cycles from the divider start pulse to its ready pulse.
    function automatic int DIV_LAT(input int n);
        return 2 * n + 2;
    endfunction

    // Watchdog limit: comfortable margin above the divider latency.
    function automatic int default_timeout(input int n);
        return 4 * n + 8;
    endfunction

endpackage

// File: rtl/div_share_ctrl_rr_picker.sv
// Round-robin picker: the first active request found after last_grant, wrapping.
// Purely combinational.
module rr_picker #(
    parameter  int NREQ = 4,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            any
);

    logic          found_s;
    logic [IW-1:0] idx_s;

    // Rotate the search start past last_grant and take the first active request.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        idx_s     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_s = IW'((int'(last_grant) + k) % NREQ);
            if (!found_s && req[idx_s]) begin
                found_s        = 1'b1;
                grant[idx_s]   = 1'b1;
                grant_idx      = idx_s;
            end else begin
                found_s = found_s;
            end
        end
        any = found_s;
    end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one external restoring divider among NREQ requesters: round-robin
// arbitration, operand latching, start/ready handshake, divide-by-zero bypass, watchdog.
module div_share_ctrl
    import div_share_pkg::*;
#(
    parameter int N       = 4,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = default_timeout(N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [N-1:0]      rsp_quot,
    output logic [N-1:0]      rsp_rem,
    output logic              rsp_dz,
    output logic              rsp_err,
    output logic              div_start,
    output logic [N-1:0]      div_a,
    output logic [N:0]        div_b,
    input  logic              div_ready,
    input  logic [N-1:0]      div_quot,
    input  logic [N:0]        div_rem
);

    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WDW = $clog2(TIMEOUT + 1);

    state_e          state_r, state_n;
    logic [IW-1:0]   last_grant_r, last_grant_n;
    logic [IW-1:0]   grant_idx_r, grant_idx_n;
    logic [WDW-1:0]  wd_cnt_r, wd_cnt_n;
    logic [NREQ-1:0] req_ready_r, req_ready_n;
    logic [NREQ-1:0] rsp_valid_r, rsp_valid_n;
    logic [N-1:0]    rsp_quot_r, rsp_quot_n;
    logic [N-1:0]    rsp_rem_r, rsp_rem_n;
    logic            rsp_dz_r, rsp_dz_n;
    logic            rsp_err_r, rsp_err_n;
    logic            div_start_r, div_start_n;
    logic [N-1:0]    div_a_r, div_a_n;
    logic [N:0]      div_b_r, div_b_n;

    logic [NREQ-1:0] pick_grant_s;
    logic [IW-1:0]   pick_idx_s;
    logic            pick_any_s;
    logic [NREQ-1:0] grant_onehot_s;
    logic            unused_div_rem_msb_s;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .req        (req_valid),
        .last_grant (last_grant_r),
        .grant      (pick_grant_s),
        .grant_idx  (pick_idx_s),
        .any        (pick_any_s)
    );

    // Restoring division always leaves the remainder MSb clear.
    assign unused_div_rem_msb_s = div_rem[N];
    assign grant_onehot_s       = {{(NREQ-1){1'b0}}, 1'b1} << grant_idx_r;

    // Next-state and next-register values; every output is a register.
    always_comb begin
        state_n      = state_r;
        last_grant_n = last_grant_r;
        grant_idx_n  = grant_idx_r;
        wd_cnt_n     = wd_cnt_r;
        req_ready_n  = '0;
        rsp_valid_n  = '0;
        rsp_quot_n   = '0;
        rsp_rem_n    = '0;
        rsp_dz_n     = 1'b0;
        rsp_err_n    = 1'b0;
        div_start_n  = 1'b0;
        div_a_n      = div_a_r;
        div_b_n      = div_b_r;
        case (state_r)
            IDLE: begin
                if (pick_any_s) begin
                    state_n     = ACCEPT;
                    grant_idx_n = pick_idx_s;
                    req_ready_n = pick_grant_s;
                    div_a_n     = req_a[int'(pick_idx_s) * N +: N];
                    div_b_n     = {1'b0, req_b[int'(pick_idx_s) * N +: N]};
                end else begin
                    state_n = IDLE;
                end
            end
            ACCEPT: begin
                last_grant_n = grant_idx_r;
                if (div_b_r == '0) begin
                    state_n     = RESP;
                    rsp_valid_n = grant_onehot_s;
                    rsp_quot_n  = '1;
                    rsp_rem_n   = div_a_r;
                    rsp_dz_n    = 1'b1;
                end else begin
                    state_n     = ISSUE;
                    div_start_n = 1'b1;
                end
            end
            ISSUE: begin
                state_n  = WAIT;
                wd_cnt_n = WDW'(1);
            end
            WAIT: begin
                // A real completion wins over a coincident watchdog expiry.
                if (div_ready) begin
                    state_n     = RESP;
                    rsp_valid_n = grant_onehot_s;
                    rsp_quot_n  = div_quot;
                    rsp_rem_n   = div_rem[N-1:0];
                end else if (wd_cnt_r == WDW'(TIMEOUT)) begin
                    state_n     = RESP;
                    rsp_valid_n = grant_onehot_s;
                    rsp_quot_n  = '1;
                    rsp_err_n   = 1'b1;
                end else begin
                    wd_cnt_n = wd_cnt_r + WDW'(1);
                end
            end
            RESP: begin
                state_n = IDLE;
                div_a_n = '0;
                div_b_n = '0;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            last_grant_r <= IW'(NREQ - 1);
            grant_idx_r  <= '0;
            wd_cnt_r     <= '0;
            req_ready_r  <= '0;
            rsp_valid_r  <= '0;
            rsp_quot_r   <= '0;
            rsp_rem_r    <= '0;
            rsp_dz_r     <= 1'b0;
            rsp_err_r    <= 1'b0;
            div_start_r  <= 1'b0;
            div_a_r      <= '0;
            div_b_r      <= '0;
        end else begin
            state_r      <= state_n;
            last_grant_r <= last_grant_n;
            grant_idx_r  <= grant_idx_n;
            wd_cnt_r     <= wd_cnt_n;
            req_ready_r  <= req_ready_n;
            rsp_valid_r  <= rsp_valid_n;
            rsp_quot_r   <= rsp_quot_n;
            rsp_rem_r    <= rsp_rem_n;
            rsp_dz_r     <= rsp_dz_n;
            rsp_err_r    <= rsp_err_n;
            div_start_r  <= div_start_n;
            div_a_r      <= div_a_n;
            div_b_r      <= div_b_n;
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_quot  = rsp_quot_r;
    assign rsp_rem   = rsp_rem_r;
    assign rsp_dz    = rsp_dz_r;
    assign rsp_err   = rsp_err_r;
    assign div_start = div_start_r;
    assign div_a     = div_a_r;
    assign div_b     = div_b_r;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Self-checking bench for div_share_ctrl: behavioural divider, arbitration and
// result model, directed plus randomized operations.
module tb_div_share_ctrl;
    import div_share_pkg::*;

    localparam int N        = 4;
    localparam int NREQ     = 4;
    localparam int TIMEOUT  = 4 * N + 8;
    localparam int NORM_LAT = DIV_LAT(N) + 2;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [N-1:0]      rsp_quot;
    logic [N-1:0]      rsp_rem;
    logic              rsp_dz;
    logic              rsp_err;
    logic              div_start;
    logic [N-1:0]      div_a;
    logic [N:0]        div_b;
    logic              div_ready;
    logic [N-1:0]      div_quot;
    logic [N:0]        div_rem;

    int checks;
    int errors;
    int tb_last;
    int reload_left;
    bit div_hang;

    typedef struct {
        int r;
        int quot;
        int rem;
        bit dz;
        bit err;
        int lat;
    } exp_t;

    div_share_ctrl #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_quot  (rsp_quot),
        .rsp_rem   (rsp_rem),
        .rsp_dz    (rsp_dz),
        .rsp_err   (rsp_err),
        .div_start (div_start),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_ready (div_ready),
        .div_quot  (div_quot),
        .div_rem   (div_rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural divider: ready DIV_LAT cycles after the start cycle, or never when hung.
    int          dcnt;
    logic [N-1:0] da, db;
    always @(posedge clk) begin
        if (reset) begin
            dcnt      <= 0;
            div_ready <= 1'b0;
            div_quot  <= '0;
            div_rem   <= '0;
            da        <= '0;
            db        <= '0;
        end else begin
            div_ready <= 1'b0;
            if (div_start && !div_hang) begin
                dcnt <= DIV_LAT(N) - 1;
                da   <= div_a;
                db   <= div_b[N-1:0];
            end else if (dcnt > 0) begin
                dcnt <= dcnt - 1;
                if (dcnt == 1) begin
                    div_ready <= 1'b1;
                    div_quot  <= da / db;
                    div_rem   <= {1'b0, da % db};
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int model_pick(input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (tb_last + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic exp_t model_op(input int r, input int a, input int b, input bit hang);
        exp_t e;
        e.r = r; e.dz = 1'b0; e.err = 1'b0;
        if (b == 0) begin
            e.quot = (1 << N) - 1; e.rem = a; e.dz = 1'b1; e.lat = 1;
        end else if (hang) begin
            e.quot = (1 << N) - 1; e.rem = 0; e.err = 1'b1; e.lat = 2 + TIMEOUT;
        end else begin
            e.quot = a / b; e.rem = a % b; e.lat = NORM_LAT;
        end
        return e;
    endfunction

    task automatic set_req(input int r, input int a, input int b);
        req_valid[r]     = 1'b1;
        req_a[r*N +: N]  = N'(a);
        req_b[r*N +: N]  = N'(b);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        chk({tag, "_rsp_data"}, 64'({rsp_quot, rsp_rem, rsp_dz, rsp_err}), 64'(0));
        chk({tag, "_div_start"}, 64'(div_start), 64'(0));
        chk({tag, "_div_ops"}, 64'({div_a, div_b}), 64'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        req_valid = '0;
        div_hang  = 1'b0;
        repeat (2) @(negedge clk);
        reset     = 1'b0;
        tb_last   = NREQ - 1;
    endtask

    // Runs until nops responses arrive; requests must be driven in an idle cycle just before.
    task automatic serve(input int nops);
        int   done, cyc, rdy_cyc, prev_rdy, prev_lat, starts, w, a, b, limit;
        exp_t e;
        done = 0; cyc = 0; rdy_cyc = 0; prev_rdy = -1; prev_lat = 0; starts = 0;
        e = model_op(0, 0, 1, 1'b0);
        limit = nops * (TIMEOUT + 8) + 10;
        while (done < nops && cyc < limit) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (div_start === 1'b1) starts++;
            if (req_ready !== '0) begin
                w = model_pick(req_valid);
                chk("grant", 64'(req_ready), (w >= 0) ? (64'(1) << w) : 64'(0));
                if (prev_rdy < 0) chk("accept_latency", 64'(cyc), 64'(1));
                else chk("accept_gap", 64'(cyc - prev_rdy), 64'(prev_lat + 2));
                if (w >= 0) begin
                    a = int'(req_a[w*N +: N]);
                    b = int'(req_b[w*N +: N]);
                    e = model_op(w, a, b, div_hang);
                    tb_last = w;
                    if (reload_left > 0) begin
                        reload_left--;
                        set_req(w, $urandom_range(0, 15), $urandom_range(1, 15));
                    end else begin
                        req_valid[w] = 1'b0;
                    end
                end
                prev_rdy = cyc; rdy_cyc = cyc; starts = 0;
            end
            if (rsp_valid !== '0) begin
                chk("rsp_valid", 64'(rsp_valid), 64'(1) << e.r);
                chk("rsp_quot", 64'(rsp_quot), 64'(e.quot));
                chk("rsp_rem", 64'(rsp_rem), 64'(e.rem));
                chk("rsp_dz", 64'(rsp_dz), 64'(e.dz));
                chk("rsp_err", 64'(rsp_err), 64'(e.err));
                chk("rsp_latency", 64'(cyc - rdy_cyc), 64'(e.lat));
                chk("div_start_count", 64'(starts), 64'(e.dz ? 0 : 1));
                prev_lat = e.lat;
                done++;
            end else begin
                chk("rsp_idle_zero", 64'({rsp_quot, rsp_rem, rsp_dz, rsp_err}), 64'(0));
            end
        end
        chk("ops_done", 64'(done), 64'(nops));
        @(negedge clk);
    endtask

    initial begin
        logic [NREQ-1:0] mask;
        int n, seen;
        bit got;
        checks = 0; errors = 0; tb_last = NREQ - 1; reload_left = 0; div_hang = 1'b0;
        reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0;

        // Reset state.
        do_reset();
        chk_zero("reset");

        // Directed single operations.
        set_req(0, 13, 3); serve(1);
        set_req(0, 15, 1); serve(1);
        set_req(0, 2, 7);  serve(1);
        set_req(2, 9, 0);  serve(1);

        // Fairness: all requesters continuously valid, requester 0 reloads once.
        do_reset();
        set_req(0, 13, 2); set_req(1, 11, 3); set_req(2, 7, 4); set_req(3, 14, 5);
        reload_left = 1;
        serve(5);
        reload_left = 0;

        // Watchdog path, then normal service again.
        div_hang = 1'b1;
        set_req(1, 5, 2); serve(1);
        div_hang = 1'b0;
        set_req(1, 6, 4); serve(1);

        // Randomized contention with occasional zero divisors.
        for (int it = 0; it < 20; it++) begin
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            n = 0;
            for (int r = 0; r < NREQ; r++) begin
                if (mask[r]) begin
                    set_req(r, $urandom_range(0, 15),
                            ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 15));
                    n++;
                end
            end
            serve(n);
        end

        // Reset while waiting on the divider.
        set_req(1, 7, 2);
        got = 1'b0;
        for (int i = 0; i < 5 && !got; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (req_ready[1] === 1'b1) got = 1'b1;
        end
        chk("rst_pre_accept", 64'(got), 64'(1));
        req_valid[1] = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_zero("mid_reset");
        reset = 1'b0;
        tb_last = NREQ - 1;
        seen = 0;
        for (int i = 0; i < 2 * NORM_LAT; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (rsp_valid !== '0) seen++;
        end
        chk("rst_no_rsp", 64'(seen), 64'(0));
        set_req(0, 11, 4); set_req(2, 8, 3);
        serve(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_share_ctrl.md
# div_share_ctrl

Round-robin controller that shares one restoring-divider instance among `NREQ` requesters. Arbitrates requests, latches operands, sequences the divider's start/ready handshake, intercepts divide-by-zero and runs a watchdog. Sits between client blocks and the divider. The divider instance is external and connected through the `div_*` ports; this block does not drive the divider's reset.

## Interface
- `N`, 4: operand and quotient width (matches divider `N`)
- `NREQ`, 4: number of requesters, at least 2
- `TIMEOUT`, 4*N+8: watchdog limit, in cycles, for waiting on `div_ready`
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `req_valid` in NREQ: request per requester; held until accepted
- `req_a` in NREQ*N: dividends; requester i occupies bits [i*N +: N]
- `req_b` in NREQ*N: divisors, same packing
- `req_ready` out NREQ: one-hot accept pulse, one cycle
- `rsp_valid` out NREQ: one-hot result pulse, one cycle, addressed to the accepted requester
- `rsp_quot` out N: quotient
- `rsp_rem` out N: remainder
- `rsp_dz` out 1: divide-by-zero flag, qualified by `rsp_valid`
- `rsp_err` out 1: watchdog-timeout flag, qualified by `rsp_valid`
- `div_start` out 1: start pulse to the divider
- `div_a` out N: registered dividend to the divider
- `div_b` out N+1: registered divisor, zero-extended
- `div_ready` in 1: divider done pulse
- `div_quot` in N: divider quotient (its A register)
- `div_rem` in N+1: divider remainder (its P register)

## Operation
- Reset values: state IDLE; all outputs 0; RR pointer selects requester 0 as highest priority.
- States:
  - IDLE → ACCEPT when any `req_valid` is high.
  - ACCEPT → RESP if the latched b==0; otherwise → ISSUE.
  - ISSUE → WAIT.
  - WAIT → RESP on `div_ready` or on timeout.
  - RESP → IDLE.
- IDLE: `rr_picker` selects winner g, searching from (last_grant+1) mod NREQ upward with wrap. Register g, `req_a[g]` and `req_b[g]`.
- ACCEPT: `req_ready[g]`=1. Update last_grant←g. A requester may drop `req_valid` after this cycle.
- ISSUE: `div_start`=1 for exactly one cycle. `div_a`/`div_b` stay stable from ACCEPT until RESP.
- WAIT: a watchdog counts cycles since ISSUE.
  - `div_ready`=1: capture `div_quot` and `div_rem[N-1:0]`; the MSb of `div_rem` is discarded (always 0 after restore).
  - Counter reaches TIMEOUT: set err, quot=all-ones, rem=0.
- Divide-by-zero: divider is never started. dz=1, quot=all-ones, rem=a.
- RESP: `rsp_valid[g]`=1. Data and flags are valid this cycle only; outputs return to 0 in IDLE.
- No response backpressure: a requester must sample on the pulse.
- Only one operation is in flight. Requests arriving meanwhile wait; `req_valid` is sampled only in IDLE.
- `div_ready` outside WAIT is ignored.
- Reset mid-operation: the controller returns to IDLE in one cycle and drops the in-flight result. The divider must be reset alongside it by the system.

## Timing
- Divider latency: `div_ready` is high 2N+2 cycles after the `div_start` cycle (LOAD, 2N DIVIDE/CHECKING cycles, final DIVIDE, READY).
- Let t0 be the first cycle in IDLE with `req_valid` set; `req_ready` is high in t0+1.
  - Normal path: ISSUE at t0+2, `div_ready` at t0+2N+4, `rsp_valid` at t0+2N+5. For N=4 that is t0+13.
  - Divide-by-zero path: `rsp_valid` at t0+2.
  - Timeout path: `rsp_valid` at t0+3+TIMEOUT.
- Throughput: back-to-back accepts are 2N+6 cycles apart (IDLE reentered every operation).
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NREQ-1,0.

## Structure
- Package `div_share_pkg`:
  - state enum constants IDLE/ACCEPT/ISSUE/WAIT/RESP, 3-bit
  - `DIV_LAT(N)` = 2N+2
  - default `TIMEOUT` expression
- Sub-module `rr_picker` (parameter NREQ):
  - inputs: request vector, last_grant index
  - outputs: one-hot grant, grant index, any
  - purely combinational, rotate-and-priority-encode

## Test plan
- N=4, requester 0, a=13, b=3 → `req_ready[0]` at t0+1, `rsp_valid[0]` at t0+13, quot=4, rem=1, dz=0, err=0.
- a=15, b=1 → quot=15, rem=0. a=2, b=7 → quot=0, rem=2.
- Requester 2, a=9, b=0 → `div_start` never pulses; `rsp_valid[2]` at t0+2, dz=1, quot=15, rem=9.
- All four requesters valid continuously with distinct operands → grant order 0,1,2,3,0; each response carries the matching requester's result; `rsp_valid` one-hot.
- Divider model that never asserts `div_ready` → `rsp_valid` at t0+3+TIMEOUT, err=1, quot=15, rem=0; next request is then served normally.
- Assert `reset` in WAIT → all outputs 0 next cycle, no `rsp_valid`; a subsequent request completes with correct results and requester 0 has priority.
